// File: rtl/vip_sync_fifo_pkg.sv
// Shared VIP definitions: default pixel width and FIFO sizing used by core and FIFO.
package vip_sync_fifo_pkg;
   localparam int VIP_DWIDTH        = 24;  // 8b RGB x3
   localparam int VIP_FIFO_AWIDTH   = 4;   // 16 entries
   localparam int VIP_FIFO_AF_LEVEL = 12;
endpackage

// File: rtl/vip_fifo_ram.sv
// Simple dual-port RAM for the pixel FIFO: one write port, one registered read port.
// Read is read-first with respect to a same-address write on the same edge, which the
// full+read+write case relies on (the oldest word is read while its slot is refilled).
module vip_fifo_ram
   import vip_sync_fifo_pkg::*;
#(
   parameter int DWIDTH = VIP_DWIDTH,
   parameter int AWIDTH = VIP_FIFO_AWIDTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic [AWIDTH-1:0] waddr,
   input  logic [DWIDTH-1:0] wdata,
   input  logic              re,
   input  logic [AWIDTH-1:0] raddr,
   output logic [DWIDTH-1:0] rdata
);
   localparam int DEPTH = 2 ** AWIDTH;

   logic [DWIDTH-1:0] mem [DEPTH];

   // Storage write; contents are deliberately left uninitialised across reset.
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   // Output register: loads on read enable, holds otherwise, clears on reset.
   always_ff @(posedge clock) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/vip_sync_fifo.sv
// Single-clock pixel FIFO with 1-cycle read latency, fill level, almost-full and sticky
// overflow/underflow flags. Flags are registered and derived from the next count so they
// change on the same edge as usedw.
module vip_sync_fifo
   import vip_sync_fifo_pkg::*;
#(
   parameter int DWIDTH   = VIP_DWIDTH,
   parameter int AWIDTH   = VIP_FIFO_AWIDTH,
   parameter int AF_LEVEL = VIP_FIFO_AF_LEVEL
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DWIDTH-1:0] ff_wdata,
   input  logic              ff_wrreq,
   output logic              ff_full,
   output logic [DWIDTH-1:0] ff_rdata,
   input  logic              ff_rdreq,
   output logic              ff_empty,
   output logic [AWIDTH:0]   usedw,
   output logic              almost_full,
   output logic              overflow,
   output logic              underflow,
   input  logic              flag_clr
);
   localparam int              DEPTH   = 2 ** AWIDTH;
   localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH + 1)'(DEPTH);
   localparam logic [AWIDTH:0] AF_C    = (AWIDTH + 1)'(AF_LEVEL);

   logic [AWIDTH-1:0] wr_ptr, rd_ptr;
   logic [AWIDTH:0]   cnt_nxt;
   logic              wr_acc, rd_acc;
   logic              ovf_evt, unf_evt;

   // A read frees a slot on the same edge, so a full FIFO still accepts rd+wr together.
   assign rd_acc  = ff_rdreq & ~ff_empty;
   assign wr_acc  = ff_wrreq & (~ff_full | rd_acc);
   assign ovf_evt = ff_wrreq & ~wr_acc;
   assign unf_evt = ff_rdreq & ff_empty;

   // Next fill level from the accepted request pair.
   always_comb begin
      cnt_nxt = usedw;
      case ({wr_acc, rd_acc})
         2'b10:   cnt_nxt = usedw + 1'b1;
         2'b01:   cnt_nxt = usedw - 1'b1;
         default: cnt_nxt = usedw;
      endcase
   end

   // Pointers, count and status flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         usedw       <= '0;
         ff_empty    <= 1'b1;
         ff_full     <= 1'b0;
         almost_full <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         usedw       <= cnt_nxt;
         ff_empty    <= (cnt_nxt == '0);
         ff_full     <= (cnt_nxt == DEPTH_C);
         almost_full <= (cnt_nxt >= AF_C);
      end
   end

   // Sticky debug flags; a new error in the clear cycle wins over the clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (overflow  & ~flag_clr) | ovf_evt;
         underflow <= (underflow & ~flag_clr) | unf_evt;
      end
   end

   vip_fifo_ram #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH)
   ) u_ram (
      .clock (clock),
      .reset (reset),
      .we    (wr_acc & ~reset),
      .waddr (wr_ptr),
      .wdata (ff_wdata),
      .re    (rd_acc & ~reset),
      .raddr (rd_ptr),
      .rdata (ff_rdata)
   );
endmodule
